// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one shift per clock.
// Optional feature macro: SIGNED_INPUT_EN (two's-complement input, sign reported on neg).
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg
);
  localparam int SW = 4*DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  if (10**DIGITS <= 2**WIDTH) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       sr_q, sr_d, adj, shifted;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                neg_q, neg_d, sgn_q, sgn_d, busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]    mag;
  logic                neg_in;

`ifdef SIGNED_INPUT_EN
  assign neg_in = bin[WIDTH-1];
  assign mag    = neg_in ? -bin : bin;
`else
  assign neg_in = 1'b0;
  assign mag    = bin;
`endif

  // Add-3 correction of every BCD nibble that would overflow past 9 when doubled
  always_comb begin
    adj = sr_q;
    for (int k = 0; k < DIGITS; k++)
      adj[WIDTH+4*k +: 4] = sr_q[WIDTH+4*k +: 4] >= 4'd5 ? sr_q[WIDTH+4*k +: 4] + 4'd3 : sr_q[WIDTH+4*k +: 4];
    shifted = {adj[SW-2:0], 1'b0};
  end

  // Next-state logic; bcd/neg only load on the final shift so the display never sees partial values
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = SHIFT;
        sr_d    = {{(4*DIGITS){1'b0}}, mag};
        cnt_d   = CW'(WIDTH);
        sgn_d   = neg_in;
      end
      SHIFT: begin
        sr_d  = shifted;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          bcd_d   = shifted[SW-1 -: 4*DIGITS];
          neg_d   = sgn_q;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  // State and registered outputs; async reset discards any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign neg  = neg_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: table-driven and scoreboard checks of bin2bcd_seq (honours SIGNED_INPUT_EN).
module tb_bin2bcd_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  bin = '0;
  logic        busy, done, neg;
  logic [11:0] bcd;

  int n_vec = 0;
  int n_bad = 0;
  logic [12:0] sb[$];

  typedef struct {logic [7:0] b; logic [11:0] bcd; logic neg;} vec_t;
  vec_t tbl[6];

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .neg(neg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] model(input logic [7:0] b);
    int m;
    logic n;
`ifdef SIGNED_INPUT_EN
    n = b[7];
    m = n ? 256 - int'(b) : int'(b);
`else
    n = 1'b0;
    m = int'(b);
`endif
    return {n, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 with bcd=%h, required no pulse", bcd);
      end else begin
        logic [12:0] e;
        e = sb.pop_front();
        chk("result_{neg,bcd}", int'({neg, bcd}), int'(e));
      end
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic conv(input logic [7:0] b, input logic [12:0] e);
    int lat;
    @(negedge clk);
    bin = b;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    wait_done(lat);
    chk("latency", lat, 8);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
    chk("idle_after_done", int'(busy), 0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [11:0] held;
`ifdef SIGNED_INPUT_EN
    tbl[0] = '{8'hFF, 12'h001, 1'b1};
    tbl[1] = '{8'h80, 12'h128, 1'b1};
    tbl[2] = '{8'h7F, 12'h127, 1'b0};
    tbl[3] = '{8'h00, 12'h000, 1'b0};
    tbl[4] = '{8'h09, 12'h009, 1'b0};
    tbl[5] = '{8'h9C, 12'h100, 1'b1};
`else
    tbl[0] = '{8'd255, 12'h255, 1'b0};
    tbl[1] = '{8'd0,   12'h000, 1'b0};
    tbl[2] = '{8'd100, 12'h100, 1'b0};
    tbl[3] = '{8'd9,   12'h009, 1'b0};
    tbl[4] = '{8'd42,  12'h042, 1'b0};
    tbl[5] = '{8'd128, 12'h128, 1'b0};
`endif
    #12;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_bcd", int'(bcd), 0);
    chk("reset_neg", int'(neg), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_start", int'(busy), 0);

    for (int i = 0; i < 6; i++) conv(tbl[i].b, {tbl[i].neg, tbl[i].bcd});

    held = bcd;
    repeat (5) @(posedge clk);
    #1;
    chk("bcd_held", int'(bcd), int'(held));

    // start held high through SHIFT with bin changing; back-to-back retrigger
    @(negedge clk);
    bin = 8'd137;
    start = 1'b1;
    sb.push_back(model(8'd137));
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    bin = 8'd42;
    sb.push_back(model(8'd42));
    chk("bcd_stable_midrun", int'(bcd), int'(held));
    wait_done(lat);
    chk("hold_start_latency", lat, 5);
    @(posedge clk); #1;
    chk("hold_start_single_pulse", int'(done), 0);
    chk("hold_start_idle", int'(busy), 0);
    @(posedge clk); #1;
    chk("retrigger_busy", int'(busy), 1);
    start = 1'b0;
    wait_done(lat);
    chk("retrigger_latency", lat, 8);
    @(posedge clk); #1;

    // asynchronous reset during shift 4 of a conversion
    @(negedge clk);
    bin = 8'd200;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_bcd", int'(bcd), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("no_done_after_rst", pulses, 0);
    chk("idle_after_rst", int'(busy), 0);

    for (int i = 0; i < 256; i++) conv(8'(i), model(8'(i)));

    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
